// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared widths and helpers for the writeback port arbiter
package wb_port_arbiter_pkg;

   localparam int XLEN         = 32;
   localparam int REG_NUM      = 32;
   localparam int RADDR_W_DFLT = 5;
   localparam int WB_NREQ      = 3;

   // Round-robin successor of a requester index, wrapping n-1 -> 0.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// rtl/wb_port_arbiter_rr_arbiter.sv - combinational round-robin arbiter (rr_arbiter)
// Grants the first active request at or after the pointer, wrapping around.
module rr_arbiter #(
   parameter  int NREQ  = 3,
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [NREQ-1:0]  grant_o,
   output logic [PTR_W-1:0] grant_idx_o
);

   always_comb begin
      int  idx;
      logic found;
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin sharing of the RegFile write port among writeback sources
// Optional busy-bit scoreboard for issue stalls is enabled by defining WB_SCOREBOARD_EN.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int NREQ    = WB_NREQ,
   parameter int RADDR_W = RADDR_W_DFLT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*RADDR_W-1:0] req_rd,
   input  logic [NREQ*XLEN-1:0]    req_wdata,
   output logic                    rf_wen,
   output logic [RADDR_W-1:0]      rf_rd,
   output logic [XLEN-1:0]         rf_wdata,
   input  logic                    issue_valid,
   input  logic [RADDR_W-1:0]      issue_rd,
   input  logic [RADDR_W-1:0]      issue_rs1,
   input  logic [RADDR_W-1:0]      issue_rs2,
   output logic                    issue_stall,
   input  logic                    flush
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               wen_q, wen_d;
   logic [RADDR_W-1:0] rd_q, rd_d;
   logic [XLEN-1:0]    wdata_q, wdata_d;

   logic [NREQ-1:0]    grant;
   logic [PTR_W-1:0]   grant_idx;
   logic               xfer;
   logic [RADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]    sel_wdata;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req_i       (req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   // Ready is forced low while reset is held, even though the grant is combinational.
   assign req_ready = rst_n ? grant : '0;
   assign xfer      = |req_ready;
   assign sel_rd    = req_rd[grant_idx*RADDR_W +: RADDR_W];
   assign sel_wdata = req_wdata[grant_idx*XLEN +: XLEN];

   always_comb begin
      ptr_d   = ptr_q;
      wen_d   = 1'b0;
      rd_d    = rd_q;
      wdata_d = wdata_q;
      if (xfer) begin
         ptr_d = PTR_W'(rr_next(int'(grant_idx), NREQ));
         // x0 writes are consumed but never reach the RegFile.
         if (sel_rd != '0) begin
            wen_d   = 1'b1;
            rd_d    = sel_rd;
            wdata_d = sel_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         wen_q   <= 1'b0;
         rd_q    <= '0;
         wdata_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         wen_q   <= wen_d;
         rd_q    <= rd_d;
         wdata_q <= wdata_d;
      end
   end

   assign rf_wen   = wen_q;
   assign rf_rd    = rd_q;
   assign rf_wdata = wdata_q;

`ifdef WB_SCOREBOARD_EN
   logic [REG_NUM-1:0] busy_q, busy_d;

   assign issue_stall = issue_valid &
                        (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);

   // Ordering: commit clear, then issue set (set wins), then flush (flush wins).
   always_comb begin
      busy_d = busy_q;
      if (wen_q) busy_d[rd_q] = 1'b0;
      if (issue_valid && !issue_stall && issue_rd != '0) busy_d[issue_rd] = 1'b1;
      if (flush) busy_d = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end
`else
   logic unused_issue;
   assign unused_issue = ^{issue_valid, issue_rd, issue_rs1, issue_rs2, flush};
   assign issue_stall  = 1'b0;
`endif

endmodule
